// File: rtl/occ_width_tracker_if.sv
// Update-port bundle for occ_width_tracker.
// The placement controller drives the master side; the tracker is the slave.
interface occ_width_tracker_if #(
    parameter int IDW = 4,
    parameter int AW  = 5
);
    logic           upd_valid;
    logic           upd_ready;
    logic           upd_op;
    logic [IDW-1:0] upd_id;
    logic [AW-1:0]  upd_amt;
    logic           upd_strike;
    logic           upd_done;
    logic           upd_err;

    modport master (
        output upd_valid, upd_op, upd_id, upd_amt, upd_strike,
        input  upd_ready, upd_done, upd_err
    );

    modport slave (
        input  upd_valid, upd_op, upd_id, upd_amt, upd_strike,
        output upd_ready, upd_done, upd_err
    );
endinterface

// File: rtl/occ_width_tracker.sv
// occ_width_tracker: per-ID cumulative occupied-width store.
// Supports add/release updates, NRD write-first registered read ports
// and a first-fit search engine.
// Optional feature macro: OCC_REJECT_CNT_EN (rejected-update counter on rej_cnt).
//
// Handshake: an update transfers on the rising edge where upd_valid and
// upd_ready are both high; the master holds its fields stable while valid
// is high and not yet accepted. mem is committed on the transfer edge and
// upd_done/upd_err are presented for exactly the following cycle.
module occ_width_tracker #(
    parameter int NUM_IDS    = 14,
    parameter int OW         = 8,
    parameter int AW         = 5,
    parameter int CAP        = 255,
    parameter int BLOCKED_ID = 13,
    parameter int NRD        = 3,
    localparam int IDW       = $clog2(NUM_IDS)
) (
    input  logic                enclk,
    input  logic                rst_n,
    occ_width_tracker_if.slave  upd,
    input  logic [NRD*IDW-1:0]  rd_id,
    output logic [NRD*OW-1:0]   rd_width,
    input  logic                fit_start,
    input  logic [AW-1:0]       fit_amt,
    output logic                fit_busy,
    output logic                fit_done,
    output logic                fit_found,
    output logic [IDW-1:0]      fit_id,
    output logic [15:0]         rej_cnt,
    output logic                fit_state_dbg
);

    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} fit_state_t;

    logic [OW-1:0]     r_mem [NUM_IDS];
    fit_state_t        r_state, w_state_nxt;
    logic [IDW-1:0]    r_idx, w_idx_nxt;
    logic [AW-1:0]     r_amt, w_amt_nxt;
    logic              r_fit_done, w_fit_done_nxt;
    logic              r_fit_found, w_fit_found_nxt;
    logic [IDW-1:0]    r_fit_id, w_fit_id_nxt;
    logic              r_upd_done, r_upd_err;
    logic [NRD*OW-1:0] r_rd_width, w_rd_nxt;

    logic              w_upd_fire;
    logic              w_id_ok;
    logic [OW-1:0]     w_cur;
    logic [OW:0]       w_sum;
    logic              w_over;
    logic              w_err;
    logic [OW-1:0]     w_new;
    logic              w_we;
    logic [OW-1:0]     w_scan_cur;
    logic              w_match;

    // Updates are only taken while the search engine is idle, so a scan sees a frozen image
    assign upd.upd_ready = rst_n && (r_state == S_IDLE);
    assign w_upd_fire    = upd.upd_valid && upd.upd_ready;
    assign upd.upd_done  = r_upd_done;
    assign upd.upd_err   = r_upd_err;
    assign rd_width      = r_rd_width;
    assign fit_busy      = (r_state == S_SCAN);
    assign fit_done      = r_fit_done;
    assign fit_found     = r_fit_found;
    assign fit_id        = r_fit_id;
    assign fit_state_dbg = r_state;

    // Decode the update: current value, candidate result and rejection reasons (strike overrides all)
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (upd.upd_id == IDW'(i)) w_cur = r_mem[i];
        end
        w_id_ok = (int'(upd.upd_id) < NUM_IDS) && (int'(upd.upd_id) != BLOCKED_ID);
        w_sum   = {1'b0, w_cur} + (OW+1)'(upd.upd_amt);
        if (upd.upd_op) w_over = (OW'(upd.upd_amt) > w_cur);
        else            w_over = (w_sum > (OW+1)'(CAP));
        w_err = !upd.upd_strike && (!w_id_ok || w_over);
        w_new = upd.upd_op ? (w_cur - OW'(upd.upd_amt)) : w_sum[OW-1:0];
        w_we  = w_upd_fire && !upd.upd_strike && !w_err;
    end

    // Occupancy storage; the blocked ID starts full and is never written
    always_ff @(posedge enclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                r_mem[i] <= (i == BLOCKED_ID) ? OW'(CAP) : '0;
            end
        end else if (w_we) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (upd.upd_id == IDW'(i)) r_mem[i] <= w_new;
            end
        end
    end

    // Update response pulse, one cycle after the transfer edge
    always_ff @(posedge enclk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_done <= 1'b0;
            r_upd_err  <= 1'b0;
        end else begin
            r_upd_done <= w_upd_fire;
            r_upd_err  <= w_upd_fire && w_err;
        end
    end

    // Read mux, write-first: a same-edge commit is forwarded; out-of-range IDs read as full
    always_comb begin
        w_rd_nxt = '0;
        for (int p = 0; p < NRD; p++) begin
            w_rd_nxt[p*OW +: OW] = OW'(CAP);
            for (int i = 0; i < NUM_IDS; i++) begin
                if (rd_id[p*IDW +: IDW] == IDW'(i)) w_rd_nxt[p*OW +: OW] = r_mem[i];
            end
            if (w_we && (rd_id[p*IDW +: IDW] == upd.upd_id)) w_rd_nxt[p*OW +: OW] = w_new;
        end
    end

    // Registered read data
    always_ff @(posedge enclk or negedge rst_n) begin
        if (!rst_n) r_rd_width <= '0;
        else        r_rd_width <= w_rd_nxt;
    end

    // Candidate test for the ID currently under scan
    always_comb begin
        w_scan_cur = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (r_idx == IDW'(i)) w_scan_cur = r_mem[i];
        end
        w_match = (int'(r_idx) != BLOCKED_ID) &&
                  (({1'b0, w_scan_cur} + (OW+1)'(r_amt)) <= (OW+1)'(CAP));
    end

    // First-fit next state: one ID per cycle, stop at first match or after the last ID
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_amt_nxt       = r_amt;
        w_fit_done_nxt  = 1'b0;
        w_fit_found_nxt = 1'b0;
        w_fit_id_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (fit_start) begin
                    w_state_nxt = S_SCAN;
                    w_amt_nxt   = fit_amt;
                    w_idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (w_match) begin
                    w_state_nxt     = S_IDLE;
                    w_fit_done_nxt  = 1'b1;
                    w_fit_found_nxt = 1'b1;
                    w_fit_id_nxt    = r_idx;
                end else if (r_idx == IDW'(NUM_IDS-1)) begin
                    w_state_nxt    = S_IDLE;
                    w_fit_done_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // First-fit state and result registers; reset discards any search in flight
    always_ff @(posedge enclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_amt       <= '0;
            r_fit_done  <= 1'b0;
            r_fit_found <= 1'b0;
            r_fit_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_amt       <= w_amt_nxt;
            r_fit_done  <= w_fit_done_nxt;
            r_fit_found <= w_fit_found_nxt;
            r_fit_id    <= w_fit_id_nxt;
        end
    end

`ifdef OCC_REJECT_CNT_EN
    logic [15:0] r_rej_cnt;

    // Saturating count of rejected updates; strikes never count as rejections
    always_ff @(posedge enclk or negedge rst_n) begin
        if (!rst_n) r_rej_cnt <= '0;
        else if (w_upd_fire && w_err && (r_rej_cnt != 16'hFFFF)) r_rej_cnt <= r_rej_cnt + 16'd1;
    end

    assign rej_cnt = r_rej_cnt;
`else
    assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_occ_width_tracker.sv
// Testbench for occ_width_tracker: directed vectors, a transaction-level
// reference model and a per-cycle compare process.
module tb_occ_width_tracker;
  localparam int NUM_IDS = 14;
  localparam int IDW     = 4;
  localparam int OW      = 8;
  localparam int AW      = 5;
  localparam int CAP     = 255;
  localparam int BLK     = 13;
  localparam int NRD     = 3;

  logic                clk;
  logic                rst_n;
  logic [NRD*IDW-1:0]  rd_id;
  logic [NRD*OW-1:0]   rd_width;
  logic                fit_start;
  logic [AW-1:0]       fit_amt;
  logic                fit_busy, fit_done, fit_found;
  logic [IDW-1:0]      fit_id;
  logic [15:0]         rej_cnt;
  logic                fit_state_dbg;

  occ_width_tracker_if #(.IDW(IDW), .AW(AW)) u_if ();

  occ_width_tracker dut (
    .enclk         (clk),
    .rst_n         (rst_n),
    .upd           (u_if.slave),
    .rd_id         (rd_id),
    .rd_width      (rd_width),
    .fit_start     (fit_start),
    .fit_amt       (fit_amt),
    .fit_busy      (fit_busy),
    .fit_done      (fit_done),
    .fit_found     (fit_found),
    .fit_id        (fit_id),
    .rej_cnt       (rej_cnt),
    .fit_state_dbg (fit_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: occupancy per ID and the outcome of each transaction
  int m_mem[NUM_IDS];
  int scan_left;
  bit res_found;
  int res_id;
  bit e_done, e_err, e_fdone, e_found;
  int e_fid;
  int e_rd[NRD];
  int e_rej;

  function automatic void model_reset();
    for (int i = 0; i < NUM_IDS; i++) m_mem[i] = (i == BLK) ? CAP : 0;
    scan_left = 0; res_found = 0; res_id = 0;
    e_done = 0; e_err = 0; e_fdone = 0; e_found = 0; e_fid = 0; e_rej = 0;
    for (int p = 0; p < NRD; p++) e_rd[p] = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int id, amt;
    bit bad, idle_now;
    if (!rst_n) begin
      model_reset();
    end else begin
      idle_now = (scan_left == 0);
      e_done = 0; e_err = 0; e_fdone = 0; e_found = 0; e_fid = 0;
      if (u_if.upd_valid && idle_now) begin
        id  = int'(u_if.upd_id);
        amt = int'(u_if.upd_amt);
        e_done = 1;
        if (!u_if.upd_strike) begin
          if (id >= NUM_IDS || id == BLK) bad = 1;
          else if (u_if.upd_op == 1'b0) bad = (m_mem[id] + amt > CAP);
          else bad = (amt > m_mem[id]);
          if (bad) begin
            e_err = 1;
`ifdef OCC_REJECT_CNT_EN
            if (e_rej < 65535) e_rej++;
`endif
          end else if (u_if.upd_op) m_mem[id] -= amt;
          else m_mem[id] += amt;
        end
      end
      if (scan_left > 0) begin
        scan_left--;
        if (scan_left == 0) begin
          e_fdone = 1; e_found = res_found; e_fid = res_id;
        end
      end else if (fit_start) begin
        res_found = 0; res_id = 0;
        for (int i = 0; i < NUM_IDS; i++)
          if (!res_found && i != BLK && m_mem[i] + int'(fit_amt) <= CAP) begin
            res_found = 1; res_id = i;
          end
        scan_left = res_found ? res_id + 1 : NUM_IDS;
      end
      for (int p = 0; p < NRD; p++) begin
        id = int'(rd_id[p*IDW +: IDW]);
        e_rd[p] = (id < NUM_IDS) ? m_mem[id] : CAP;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("upd_ready", u_if.upd_ready, (rst_n && scan_left == 0) ? 1 : 0);
      check("upd_done", u_if.upd_done, e_done);
      if (e_done) check("upd_err", u_if.upd_err, e_err);
      check("fit_busy", fit_busy, (scan_left > 0) ? 1 : 0);
      check("fit_done", fit_done, e_fdone);
      if (e_fdone) begin
        check("fit_found", fit_found, e_found);
        check("fit_id", fit_id, e_fid);
      end
      for (int p = 0; p < NRD; p++) check("rd_width", rd_width[p*OW +: OW], e_rd[p]);
      check("rej_cnt", rej_cnt, e_rej);
    end
  end

  // driver tasks
  task automatic do_upd(input bit op, input int id, input int amt, input bit strike);
    u_if.upd_valid  = 1'b1;
    u_if.upd_op     = op;
    u_if.upd_id     = IDW'(id);
    u_if.upd_amt    = AW'(amt);
    u_if.upd_strike = strike;
    @(negedge clk);
    u_if.upd_valid  = 1'b0;
    u_if.upd_strike = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b, input int c);
    rd_id = {IDW'(c), IDW'(b), IDW'(a)};
  endtask

  task automatic read_one(input int id, input int exp, input string nm);
    set_rd(id, 0, 0);
    @(negedge clk);
    check(nm, rd_width[OW-1:0], exp);
  endtask

  task automatic fill(input int id, input int target);
    int cur;
    cur = 0;
    while (cur < target) begin
      do_upd(1'b0, id, (target - cur > 31) ? 31 : target - cur, 1'b0);
      cur += (target - cur > 31) ? 31 : target - cur;
    end
  endtask

  // start a search (fit_start held for two edges; the second must be ignored)
  task automatic run_fit(input int amt, output int busy, output bit got);
    fit_start = 1'b1;
    fit_amt   = AW'(amt);
    busy = 0;
    got  = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      u_if.upd_valid = 1'b0;
      if (c == 1) fit_start = 1'b0;
      if (fit_done) got = 1;
      else if (fit_busy) busy++;
    end
    fit_start = 1'b0;
    if (!got) check("fit_timeout", 0, 1);
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    @(negedge clk);
    chk_en = 1;
  endtask

  initial begin
    int busy;
    bit got;
    int cnt;
    model_reset();
    rst_n = 1'b0;
    u_if.upd_valid = 0; u_if.upd_op = 0; u_if.upd_id = '0;
    u_if.upd_amt = '0; u_if.upd_strike = 0;
    rd_id = '0; fit_start = 0; fit_amt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // reset state
    set_rd(0, 5, 13);
    @(negedge clk);
    check("rst_rd0", rd_width[0 +: OW], 0);
    check("rst_rd1", rd_width[OW +: OW], 0);
    check("rst_rd2", rd_width[2*OW +: OW], 255);
    check("rst_ready", u_if.upd_ready, 1);
    check("rst_busy", fit_busy, 0);
    check("rst_rej", rej_cnt, 0);

    // back-to-back adds to ID 2 until capacity rejects
    set_rd(2, 0, 0);
    for (int i = 0; i < 17; i++) begin
      do_upd(1'b0, 2, 16, 1'b0);
      check("add2_err", u_if.upd_err, (i < 15) ? 0 : 1);
    end
    @(negedge clk);
    check("mem2", rd_width[0 +: OW], 240);
`ifdef OCC_REJECT_CNT_EN
    check("rej_after_cap", rej_cnt, 2);
`endif

    // add / over-release / release on ID 4, with write-first forwarding
    set_rd(4, 2, 13);
    do_upd(1'b0, 4, 10, 1'b0);
    check("wf_add4", rd_width[0 +: OW], 10);
    do_upd(1'b1, 4, 11, 1'b0);
    check("rel4_err", u_if.upd_err, 1);
    check("rel4_keep", rd_width[0 +: OW], 10);
    do_upd(1'b1, 4, 10, 1'b0);
    check("rel4_ok", u_if.upd_err, 0);
    check("wf_rel4", rd_width[0 +: OW], 0);

    // strike and illegal targets
    set_rd(1, 15, 13);
    do_upd(1'b0, 1, 7, 1'b1);
    check("strike_done", u_if.upd_done, 1);
    check("strike_err", u_if.upd_err, 0);
    check("strike_mem", rd_width[0 +: OW], 0);
    do_upd(1'b0, 13, 1, 1'b0);
    check("blk_add", u_if.upd_err, 1);
    do_upd(1'b1, 13, 1, 1'b0);
    check("blk_rel", u_if.upd_err, 1);
    check("blk_mem", rd_width[2*OW +: OW], 255);
    do_upd(1'b0, 14, 1, 1'b0);
    check("oor_add", u_if.upd_err, 1);
    do_upd(1'b1, 15, 0, 1'b1);
    check("oor_strike", u_if.upd_err, 0);
    check("oor_rd", rd_width[OW +: OW], 255);
    @(negedge clk);

    // first fit lands on ID 3
    do_reset();
    for (int i = 0; i < 3; i++) fill(i, 250);
    run_fit(8, busy, got);
    check("fit3_busy", busy, 4);
    check("fit3_found", fit_found, 1);
    check("fit3_id", fit_id, 3);

    // nothing fits
    for (int i = 3; i < 13; i++) fill(i, 250);
    run_fit(6, busy, got);
    check("nofit_busy", busy, 14);
    check("nofit_found", fit_found, 0);
    check("nofit_id", fit_id, 0);

    // update and search start on the same edge: search sees the release
    u_if.upd_valid = 1'b1; u_if.upd_op = 1'b1; u_if.upd_id = 4'd5;
    u_if.upd_amt = 5'd10; u_if.upd_strike = 1'b0;
    run_fit(6, busy, got);
    check("same_edge_found", fit_found, 1);
    check("same_edge_id", fit_id, 5);
    check("same_edge_busy", busy, 6);

    // reset in the middle of a scan
    fit_start = 1'b1; fit_amt = 5'd6;
    @(negedge clk);
    fit_start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", fit_busy, 1);
    chk_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy_rst", fit_busy, 0);
    check("mid_done_rst", fit_done, 0);
    check("mid_ready_rst", u_if.upd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;
    check("mid_ready", u_if.upd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fit_done) cnt++;
    end
    check("mid_no_done", cnt, 0);
    read_one(5, 0, "mid_mem5");
    read_one(13, 255, "mid_mem13");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog t=%0t", $time);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
